anti_theft_ctrl: RTL

//  Main sequencer of the automotive anti-theft system. Watches ignition and door sensors and arms/disarms the car.

---
 rtl/anti_theft_pkg.sv | 37 +++
 rtl/time_param_bank.sv | 58 +++++
 rtl/anti_theft_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/anti_theft_pkg.sv
// Shared encodings and default intervals for the anti-theft sequencer.
// Interval reprogramming is enabled by defining TIME_PARAM_PROG_EN.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        StDisarmed  = 3'd0,
        StWaitOpen  = 3'd1,
        StWaitClose = 3'd2,
        StArmDelay  = 3'd3,
        StArmed     = 3'd4,
        StTriggered = 3'd5,
        StAlarmOn   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SelArm       = 2'd0,
        SelDriver    = 2'd1,
        SelPassenger = 2'd2,
        SelAlarm     = 2'd3
    } param_sel_e;

    localparam logic [3:0] DefArmDelay       = 4'd6;
    localparam logic [3:0] DefDriverDelay    = 4'd8;
    localparam logic [3:0] DefPassengerDelay = 4'd15;
    localparam logic [3:0] DefAlarmOn        = 4'd10;

    // Timer load sequence: abort, start, one settle cycle, then expiry is trusted.
    localparam logic [1:0] LoadIdle   = 2'd0;
    localparam logic [1:0] LoadAbort  = 2'd1;
    localparam logic [1:0] LoadStart  = 2'd2;
    localparam logic [1:0] LoadSettle = 2'd3;

    function automatic logic is_timed(state_e s);
        return (s == StArmDelay) || (s == StTriggered) || (s == StAlarmOn);
    endfunction

endpackage

// File: rtl/time_param_bank.sv
// Interval register file for the four countdown lengths.
// With TIME_PARAM_PROG_EN the entries are writable; otherwise a constant mux.
module time_param_bank
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY       = DefArmDelay,
    parameter logic [3:0] T_DRIVER_DELAY    = DefDriverDelay,
    parameter logic [3:0] T_PASSENGER_DELAY = DefPassengerDelay,
    parameter logic [3:0] T_ALARM_ON        = DefAlarmOn
) (
`ifdef TIME_PARAM_PROG_EN
    input  logic       clock,
    input  logic       reset,
    input  logic       reprogram,
    input  param_sel_e time_param_sel,
    input  logic [3:0] time_value,
`endif
    input  param_sel_e rd_sel,
    output logic [3:0] rd_value
);

`ifdef TIME_PARAM_PROG_EN
    logic [3:0] param_q [4];
    logic [3:0] param_d [4];

    always_comb begin
        param_d = param_q;
        if (reprogram) begin
            param_d[time_param_sel] = time_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            param_q[SelArm]       <= T_ARM_DELAY;
            param_q[SelDriver]    <= T_DRIVER_DELAY;
            param_q[SelPassenger] <= T_PASSENGER_DELAY;
            param_q[SelAlarm]     <= T_ALARM_ON;
        end else begin
            param_q <= param_d;
        end
    end

    // Reads the stored value, so a same-cycle write only affects later loads.
    assign rd_value = param_q[rd_sel];
`else
    always_comb begin
        rd_value = T_ARM_DELAY;
        unique case (rd_sel)
            SelArm:       rd_value = T_ARM_DELAY;
            SelDriver:    rd_value = T_DRIVER_DELAY;
            SelPassenger: rd_value = T_PASSENGER_DELAY;
            SelAlarm:     rd_value = T_ALARM_ON;
        endcase
    end
`endif

endmodule

// File: rtl/anti_theft_ctrl.sv
// Anti-theft main sequencer: arming FSM, countdown timer load sequencer, siren/LED drive.
// Optional interval reprogramming ports are added when TIME_PARAM_PROG_EN is defined.
module anti_theft_ctrl
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] T_ARM_DELAY       = DefArmDelay,
    parameter logic [3:0] T_DRIVER_DELAY    = DefDriverDelay,
    parameter logic [3:0] T_PASSENGER_DELAY = DefPassengerDelay,
    parameter logic [3:0] T_ALARM_ON        = DefAlarmOn
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       expired,
    input  logic       one_hz_enable,
    input  logic       two_hz_enable,
`ifdef TIME_PARAM_PROG_EN
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
`endif
    output logic       timer_abort,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_dbg
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       abort_q, abort_d;
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;

    logic       load_req;
    logic       abort_only;
    param_sel_e load_sel;
    logic [3:0] load_interval;
    logic       any_door;
    logic       expiry_seen;
    logic       unused_two_hz;

    assign unused_two_hz = two_hz_enable;
    assign any_door      = door_driver | door_pass;
    // The timer's expired level is stale until the freshly loaded count has settled.
    assign expiry_seen   = expired & (phase_q == LoadIdle);

    time_param_bank #(
        .T_ARM_DELAY       (T_ARM_DELAY),
        .T_DRIVER_DELAY    (T_DRIVER_DELAY),
        .T_PASSENGER_DELAY (T_PASSENGER_DELAY),
        .T_ALARM_ON        (T_ALARM_ON)
    ) u_time_param_bank (
`ifdef TIME_PARAM_PROG_EN
        .clock          (clock),
        .reset          (reset),
        .reprogram      (reprogram),
        .time_param_sel (param_sel_e'(time_param_sel)),
        .time_value     (time_value),
`endif
        .rd_sel         (load_sel),
        .rd_value       (load_interval)
    );

    always_comb begin : fsm_next
        state_d    = state_q;
        load_req   = 1'b0;
        load_sel   = SelArm;
        abort_only = 1'b0;
        if (ignition) begin
            state_d    = StDisarmed;
            abort_only = is_timed(state_q);
        end else begin
            case (state_q)
                StDisarmed: state_d = StWaitOpen;
                StWaitOpen: begin
                    if (door_driver) state_d = StWaitClose;
                end
                StWaitClose: begin
                    if (!any_door) begin
                        state_d  = StArmDelay;
                        load_req = 1'b1;
                        load_sel = SelArm;
                    end
                end
                StArmDelay: begin
                    if (any_door) begin
                        state_d = StWaitClose;
                    end else if (expiry_seen) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (door_driver) begin
                        state_d  = StTriggered;
                        load_req = 1'b1;
                        load_sel = SelDriver;
                    end else if (door_pass) begin
                        state_d  = StTriggered;
                        load_req = 1'b1;
                        load_sel = SelPassenger;
                    end
                end
                StTriggered: begin
                    if (expiry_seen) begin
                        state_d  = StAlarmOn;
                        load_req = 1'b1;
                        load_sel = SelAlarm;
                    end
                end
                StAlarmOn: begin
                    if (expiry_seen) begin
                        if (any_door) begin
                            load_req = 1'b1;
                            load_sel = SelAlarm;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                default: state_d = StDisarmed;
            endcase
        end
    end

    always_comb begin : out_next
        phase_d = phase_q;
        if (load_req) begin
            phase_d = LoadAbort;
        end else if (state_d != state_q) begin
            // Leaving without a new load drops any pending start.
            phase_d = LoadIdle;
        end else if (phase_q != LoadIdle) begin
            phase_d = phase_q + 2'd1;
        end

        abort_d = load_req | abort_only;
        start_d = (phase_d == LoadStart);
        value_d = load_req ? load_interval : value_q;
        siren_d = (state_d == StAlarmOn);

        led_d = 1'b0;
        case (state_d)
            StArmed: begin
                if (state_q == StArmed) led_d = led_q ^ one_hz_enable;
            end
            StTriggered, StAlarmOn: led_d = 1'b1;
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StDisarmed;
            phase_q <= LoadIdle;
            abort_q <= 1'b0;
            start_q <= 1'b0;
            value_q <= 4'd0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            abort_q <= abort_d;
            start_q <= start_d;
            value_q <= value_d;
            siren_q <= siren_d;
            led_q   <= led_d;
        end
    end

    assign timer_abort = abort_q;
    assign start_timer = start_q;
    assign timer_value = value_q;
    assign siren       = siren_q;
    assign status_led  = led_q;
    assign state_dbg   = state_q;

endmodule
